// File: rtl/ex_mem_reg.sv
// Execute-to-memory pipeline register.
// Captures the ALU result, the flags and the memory/writeback control bundle.
// Supports stall (hold) and flush (bubble).
// Squashes the side effects of instructions that trap on signed overflow.
// Keeps a sticky overflow exception with the faulting PC and a saturating trap count.
`timescale 1ns/1ps
module ex_mem_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] alu_result_i,
  input  logic        zero_i,
  input  logic        overflow_i,
  input  logic        ovf_trap_en_i,
  input  logic [31:0] rt_data_i,
  input  logic [4:0]  write_reg_i,
  input  logic        reg_write_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        mem_to_reg_i,
  input  logic        branch_i,
  input  logic        exc_clear_i,
  output logic        valid_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] rt_data_o,
  output logic [4:0]  write_reg_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        mem_to_reg_o,
  output logic        branch_taken_o,
  output logic        fwd_valid_o,
  output logic        exc_o,
  output logic [31:0] epc_o,
  output logic [7:0]  exc_count_o
);

  logic load;
  logic trap;
  logic trap_accept;

  // Decode this edge's action and whether a trap is actually accepted.
  always_comb begin
    load        = !flush_i && !stall_i;
    trap        = valid_i && ovf_trap_en_i && overflow_i;
    trap_accept = load && trap;
  end

  // Pipeline fields: flush beats stall, and stall beats load.
  // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: the reset is asynchronous, so it sits in the sensitivity list and is tested first.
    if (rst_i) begin
      valid_o        <= 1'b0;
      alu_result_o   <= '0;
      rt_data_o      <= '0;
      write_reg_o    <= '0;
      reg_write_o    <= 1'b0;
      mem_read_o     <= 1'b0;
      mem_write_o    <= 1'b0;
      mem_to_reg_o   <= 1'b0;
      branch_taken_o <= 1'b0;
    end else if (flush_i) begin
      valid_o        <= 1'b0;
      alu_result_o   <= '0;
      rt_data_o      <= '0;
      write_reg_o    <= '0;
      reg_write_o    <= 1'b0;
      mem_read_o     <= 1'b0;
      mem_write_o    <= 1'b0;
      mem_to_reg_o   <= 1'b0;
      branch_taken_o <= 1'b0;
    end else if (!stall_i) begin
      // A trapping instruction stays valid and keeps its ALU result for debug.
      // Its register and memory side effects are squashed.
      valid_o        <= valid_i;
      alu_result_o   <= alu_result_i;
      rt_data_o      <= rt_data_i;
      write_reg_o    <= write_reg_i;
      reg_write_o    <= reg_write_i && valid_i && !trap;
      mem_read_o     <= mem_read_i  && valid_i && !trap;
      mem_write_o    <= mem_write_i && valid_i && !trap;
      mem_to_reg_o   <= mem_to_reg_i && valid_i;
      branch_taken_o <= branch_i && zero_i && valid_i;
    end
  end

  // Sticky exception: the first trap's PC wins until cleared, and the count saturates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exc_o       <= 1'b0;
      epc_o       <= '0;
      exc_count_o <= '0;
    end else if (trap_accept) begin
      if (exc_count_o != 8'hFF) begin
        exc_count_o <= exc_count_o + 8'd1;
      end
      if (!exc_o || exc_clear_i) begin
        exc_o <= 1'b1;
        epc_o <= pc_i;
      end
    end else if (exc_clear_i) begin
      exc_o <= 1'b0;
    end
  end

  // Forwarding qualifier, derived only from registered state.
  always_comb begin
    fwd_valid_o = valid_o && reg_write_o && (write_reg_o != 5'd0);
  end

endmodule
